energy_trip_controller: RTL and testbench
=========================================

Name: energy_trip_controller

Overview:
- Downstream stage of the combinational energy meter; consumes its `power` and `over_load` outputs once per sample strobe.
- Integrates power into a saturating energy total and tracks peak power.
- Debounces overload into a relay trip, then retries after a cooldown.
- Latches a lockout after too many retries or when the energy budget is exceeded.

Parameters:
- PWR_W, 16, width of the power input and of peak_power.
- ENERGY_W, 32, width of the energy accumulator and of energy_limit.
- TRIP_DEBOUNCE, 4, consecutive overloaded valid samples needed to trip (≥1).
- COOLDOWN, 16, cycles the relay stays open in TRIP (≥1).
- MAX_RETRY, 3, number of trips that forces LOCK (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; reset=0 at a clk edge resets the block.
- enable  input  1  run request; same signal that enables the meter.
- sample_valid  input  1  power and over_load are valid this cycle.
- power  input  PWR_W  instantaneous power from the meter.
- over_load  input  1  overload flag from the meter.
- energy_limit  input  ENERGY_W  energy budget; 0 disables the budget check.
- clear  input  1  operator clear/acknowledge, single-cycle pulse.
- relay_on  output  1  load relay closed.
- tripped  output  1  high while in TRIP.
- lockout  output  1  high while in LOCK.
- energy_alarm  output  1  sticky flag: budget exceeded.
- state  output  2  IDLE=00, RUN=01, TRIP=10, LOCK=11.
- energy  output  ENERGY_W  accumulated energy, saturating.
- sample_count  output  16  valid samples accumulated, saturating at 0xFFFF.
- peak_power  output  PWR_W  maximum power seen since last clear.
- retry_count  output  2  trips since last clear.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at an edge) has priority over everything. It sets state=IDLE and zeroes all counters, accumulators and flags, so relay_on=0.
- relay_on=1 iff state=RUN; tripped=1 iff state=TRIP; lockout=1 iff state=LOCK.
- IDLE:
  - enable=1 → RUN on the next edge; relay_on is high one cycle after enable rises.
  - Samples are ignored in IDLE.
- RUN, on each sample_valid cycle:
  - energy ← min(energy+power, 2^ENERGY_W−1).
  - sample_count ← saturating +1.
  - peak_power ← max(peak_power, power).
  - over_load=1 increments the debounce counter; over_load=0 zeroes it. Cycles without sample_valid hold it.
- RUN exit priority, evaluated after this cycle's update:
  1. enable=0 → IDLE; the debounce counter is zeroed.
  2. energy_limit≠0 and updated energy ≥ energy_limit → set energy_alarm and go to LOCK.
  3. Debounce counter reaches TRIP_DEBOUNCE → TRIP. The tripping sample is still accumulated. state=TRIP on the edge after the Nth overloaded sample.
- Entering TRIP:
  - Load the cooldown counter with COOLDOWN.
  - retry_count ← retry_count+1, saturating at 3.
  - Zero the debounce counter.
- TRIP:
  - Samples are not accumulated.
  - The cooldown counter decrements each cycle. On the cycle it reads 1, the next state is:
    - LOCK if retry_count ≥ MAX_RETRY;
    - else RUN if enable=1;
    - else IDLE.
  - The relay is therefore open for exactly COOLDOWN cycles.
- LOCK:
  - Sticky; enable and samples are ignored.
  - Left only via clear → IDLE.
- clear (any state):
  - Zeroes energy, sample_count, peak_power, retry_count, energy_alarm and the debounce counter.
  - LOCK → IDLE.
  - RUN and TRIP keep their state; TRIP's cooldown continues.
  - If clear and sample_valid occur in the same cycle, clear wins and the sample is discarded.
- Saturation: energy and sample_count hold at their maximum value and never wrap.
- Simultaneous events:
  - enable=0 in the same RUN cycle as a trip or budget condition → IDLE wins.
  - A budget condition beats a trip condition.

Test Plan:
- Reset then enable with PWR_W=16 and valid samples power=100, 200, 50 with over_load=0 → relay_on=1, energy=350, sample_count=3, peak_power=200, state=RUN.
- Overload debounce: over_load=1 on 3 valid samples, then 0, then 4 consecutive 1s → no trip after the first 3. state=TRIP on the edge after the 4th; relay_on=0 for exactly 16 cycles, then RUN; retry_count=1.
- Three full trip cycles with enable held high → after the third cooldown, state=LOCK, lockout=1. enable toggling has no effect; clear → IDLE with retry_count=0.
- Budget: energy_limit=1000, samples of 400 → third sample gives energy=1200, energy_alarm=1 and state=LOCK on the next edge. energy_limit=0 with the same stimulus → stays RUN.
- Saturation: preload energy near 2^32−1 (e.g. 0xFFFFFF00), sample power=0xFFFF → energy=0xFFFFFFFF and holds on further samples.
- Corner cases:
  - reset=0 mid-TRIP → all outputs zero, IDLE.
  - clear coinciding with sample_valid → energy=0, sample discarded.
  - enable=0 on the 4th overloaded sample → IDLE, not TRIP.

Source files
------------

// File: rtl/energy_trip_controller.sv
// Energy meter back end: integrates power, debounces overload into relay trips
// with cooldown/retry, and latches a lockout on retry exhaustion or budget overrun.
module energy_trip_controller #(
    parameter int unsigned PWR_W         = 16,
    parameter int unsigned ENERGY_W      = 32,
    parameter int unsigned TRIP_DEBOUNCE = 4,
    parameter int unsigned COOLDOWN      = 16,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [PWR_W-1:0]    power,
    input  logic                over_load,
    input  logic [ENERGY_W-1:0] energy_limit,
    input  logic                clear,
    output logic                relay_on,
    output logic                tripped,
    output logic                lockout,
    output logic                energy_alarm,
    output logic [1:0]          state,
    output logic [ENERGY_W-1:0] energy,
    output logic [15:0]         sample_count,
    output logic [PWR_W-1:0]    peak_power,
    output logic [1:0]          retry_count
);

    localparam int unsigned DEB_W  = $clog2(TRIP_DEBOUNCE + 1);
    localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);
    localparam int unsigned SUM_W  = ENERGY_W + 1;

    localparam logic [DEB_W-1:0]    DEB_TRIP   = DEB_W'(TRIP_DEBOUNCE);
    localparam logic [COOL_W-1:0]   COOL_INIT  = COOL_W'(COOLDOWN);
    localparam logic [ENERGY_W-1:0] ENERGY_MAX = {ENERGY_W{1'b1}};
    localparam logic [15:0]         CNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRIP = 2'b10,
        ST_LOCK = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [ENERGY_W-1:0] energy_q, energy_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [PWR_W-1:0]    peak_q, peak_d;
    logic [1:0]          retry_q, retry_d;
    logic                alarm_q, alarm_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [COOL_W-1:0]   cool_q, cool_d;
    logic                relay_q, tripped_q, lockout_q;
    logic [SUM_W-1:0]    energy_sum;

    // Accumulation and clear first, so exit decisions see this cycle's updated values.
    always_comb begin
        state_d    = state_q;
        energy_d   = energy_q;
        cnt_d      = cnt_q;
        peak_d     = peak_q;
        retry_d    = retry_q;
        alarm_d    = alarm_q;
        deb_d      = deb_q;
        cool_d     = cool_q;
        energy_sum = {1'b0, energy_q} + SUM_W'(power);

        if (state_q == ST_RUN && sample_valid && !clear) begin
            energy_d = energy_sum[ENERGY_W] ? ENERGY_MAX : energy_sum[ENERGY_W-1:0];
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 16'd1;
            end
            if (power > peak_q) begin
                peak_d = power;
            end
            deb_d = over_load ? deb_q + DEB_W'(1) : '0;
        end

        if (clear) begin
            energy_d = '0;
            cnt_d    = '0;
            peak_d   = '0;
            retry_d  = '0;
            alarm_d  = 1'b0;
            deb_d    = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    deb_d   = '0;
                end else if (energy_limit != '0 && energy_d >= energy_limit) begin
                    alarm_d = 1'b1;
                    state_d = ST_LOCK;
                end else if (deb_d == DEB_TRIP) begin
                    state_d = ST_TRIP;
                    cool_d  = COOL_INIT;
                    deb_d   = '0;
                    if (retry_d != 2'd3) begin
                        retry_d = retry_d + 2'd1;
                    end
                end
            end
            ST_TRIP: begin
                cool_d = cool_q - COOL_W'(1);
                if (cool_q == COOL_W'(1)) begin
                    if (32'(retry_d) >= MAX_RETRY) begin
                        state_d = ST_LOCK;
                    end else if (enable) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCK: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            energy_q  <= '0;
            cnt_q     <= '0;
            peak_q    <= '0;
            retry_q   <= '0;
            alarm_q   <= 1'b0;
            deb_q     <= '0;
            cool_q    <= '0;
            relay_q   <= 1'b0;
            tripped_q <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            energy_q  <= energy_d;
            cnt_q     <= cnt_d;
            peak_q    <= peak_d;
            retry_q   <= retry_d;
            alarm_q   <= alarm_d;
            deb_q     <= deb_d;
            cool_q    <= cool_d;
            relay_q   <= (state_d == ST_RUN);
            tripped_q <= (state_d == ST_TRIP);
            lockout_q <= (state_d == ST_LOCK);
        end
    end

    assign relay_on     = relay_q;
    assign tripped      = tripped_q;
    assign lockout      = lockout_q;
    assign energy_alarm = alarm_q;
    assign state        = state_q;
    assign energy       = energy_q;
    assign sample_count = cnt_q;
    assign peak_power   = peak_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_energy_trip_controller.sv
// Bench for energy_trip_controller: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_energy_trip_controller;

    localparam int unsigned PW = 16;
    localparam int unsigned EW = 20;
    localparam int unsigned TD = 4;
    localparam int unsigned CD = 16;
    localparam int unsigned MR = 3;
    localparam longint EMAX = (64'd1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset, enable, sample_valid, over_load, clear;
    logic [PW-1:0] power;
    logic [EW-1:0] energy_limit;
    logic          relay_on, tripped, lockout, energy_alarm;
    logic [1:0]    state, retry_count;
    logic [EW-1:0] energy;
    logic [15:0]   sample_count;
    logic [PW-1:0] peak_power;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    energy_trip_controller #(
        .PWR_W(PW), .ENERGY_W(EW), .TRIP_DEBOUNCE(TD), .COOLDOWN(CD), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .power(power), .over_load(over_load), .energy_limit(energy_limit), .clear(clear),
        .relay_on(relay_on), .tripped(tripped), .lockout(lockout),
        .energy_alarm(energy_alarm), .state(state), .energy(energy),
        .sample_count(sample_count), .peak_power(peak_power), .retry_count(retry_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modes 0=idle 1=run 2=trip 3=lock
    int     m_st, m_cnt, m_pk, m_retry, m_deb, m_cool;
    longint m_e;
    bit     m_alarm;
    bit     m_ok = 0;

    always @(posedge clk) begin
        int nxt;
        if (!reset) begin
            m_st = 0; m_e = 0; m_cnt = 0; m_pk = 0; m_retry = 0;
            m_deb = 0; m_cool = 0; m_alarm = 0; m_ok = 1;
        end else if (m_ok) begin
            nxt = m_st;
            if (m_st == 1 && sample_valid && !clear) begin
                m_e   = (m_e + longint'(power) > EMAX) ? EMAX : m_e + longint'(power);
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_pk  = (int'(power) > m_pk) ? int'(power) : m_pk;
                m_deb = over_load ? m_deb + 1 : 0;
            end
            if (clear) begin
                m_e = 0; m_cnt = 0; m_pk = 0; m_retry = 0; m_alarm = 0; m_deb = 0;
            end
            if (m_st == 0) begin
                if (enable) nxt = 1;
            end else if (m_st == 1) begin
                if (!enable) begin
                    nxt = 0; m_deb = 0;
                end else if (energy_limit != 0 && m_e >= longint'(energy_limit)) begin
                    m_alarm = 1; nxt = 3;
                end else if (m_deb >= int'(TD)) begin
                    nxt = 2; m_cool = CD; m_deb = 0;
                    m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                end
            end else if (m_st == 2) begin
                if (m_cool == 1) nxt = (m_retry >= int'(MR)) ? 3 : (enable ? 1 : 0);
                m_cool = m_cool - 1;
            end else begin
                if (clear) nxt = 0;
            end
            m_st = nxt;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (m_ok) begin
            chk("state", 64'(state), 64'(m_st));
            chk("relay_on", 64'(relay_on), 64'(m_st == 1));
            chk("tripped", 64'(tripped), 64'(m_st == 2));
            chk("lockout", 64'(lockout), 64'(m_st == 3));
            chk("energy_alarm", 64'(energy_alarm), 64'(m_alarm));
            chk("energy", 64'(energy), 64'(m_e));
            chk("sample_count", 64'(sample_count), 64'(m_cnt));
            chk("peak_power", 64'(peak_power), 64'(m_pk));
            chk("retry_count", 64'(retry_count), 64'(m_retry));
        end
    end

    task automatic cyc(input bit sv, input int pw, input bit ol);
        sample_valid = sv;
        power        = PW'(pw);
        over_load    = ol;
        @(negedge clk);
        sample_valid = 1'b0;
        over_load    = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic wait_trip_end(output int n);
        n = 0;
        while (tripped === 1'b1 && n < 40) begin
            n++;
            cyc(0, 0, 0);
        end
    endtask

    int n;

    initial begin
        reset = 1'b0; enable = 1'b0; sample_valid = 1'b0; over_load = 1'b0;
        clear = 1'b0; power = '0; energy_limit = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_relay", 64'(relay_on), 64'd0);
        chk("rst_energy", 64'(energy), 64'd0);
        reset = 1'b1;

        // Basic accumulation
        enable = 1'b1;
        cyc(0, 0, 0);
        chk("en_relay", 64'(relay_on), 64'd1);
        cyc(1, 100, 0); cyc(1, 200, 0); cyc(1, 50, 0);
        chk("acc_energy", 64'(energy), 64'd350);
        chk("acc_count", 64'(sample_count), 64'd3);
        chk("acc_peak", 64'(peak_power), 64'd200);
        chk("acc_state", 64'(state), 64'd1);

        // Debounce: 3 overloads, a break, then 4 in a row
        repeat (3) cyc(1, 10, 1);
        chk("deb3_state", 64'(state), 64'd1);
        cyc(1, 10, 0);
        repeat (3) cyc(1, 10, 1);
        chk("deb_break_state", 64'(state), 64'd1);
        cyc(1, 10, 1);
        chk("trip_state", 64'(state), 64'd2);
        chk("trip_relay", 64'(relay_on), 64'd0);
        chk("trip_retry", 64'(retry_count), 64'd1);
        wait_trip_end(n);
        chk("cooldown_len", 64'(n), 64'd16);
        chk("retry1_state", 64'(state), 64'd1);

        // Second and third trips lead to lockout
        repeat (4) cyc(1, 10, 1);
        wait_trip_end(n);
        chk("retry2_state", 64'(state), 64'd1);
        chk("retry2_count", 64'(retry_count), 64'd2);
        repeat (4) cyc(1, 10, 1);
        chk("retry3_count", 64'(retry_count), 64'd3);
        wait_trip_end(n);
        chk("lock_state", 64'(state), 64'd3);
        chk("lock_flag", 64'(lockout), 64'd1);
        chk("lock_energy", 64'(energy), 64'd510);
        enable = 1'b0; cyc(1, 999, 0); cyc(1, 999, 0);
        enable = 1'b1; cyc(1, 999, 1);
        chk("lock_sticky", 64'(state), 64'd3);
        chk("lock_no_acc", 64'(energy), 64'd510);
        clear = 1'b1; cyc(0, 0, 0);
        chk("clr_state", 64'(state), 64'd0);
        chk("clr_retry", 64'(retry_count), 64'd0);
        chk("clr_energy", 64'(energy), 64'd0);
        cyc(0, 0, 0);
        chk("rerun_state", 64'(state), 64'd1);

        // Energy budget
        energy_limit = EW'(1000);
        cyc(1, 400, 0); cyc(1, 400, 0);
        chk("bud_pre_state", 64'(state), 64'd1);
        cyc(1, 400, 0);
        chk("bud_energy", 64'(energy), 64'd1200);
        chk("bud_alarm", 64'(energy_alarm), 64'd1);
        chk("bud_state", 64'(state), 64'd3);
        clear = 1'b1; cyc(0, 0, 0);
        energy_limit = '0;
        cyc(0, 0, 0);
        repeat (3) cyc(1, 400, 0);
        chk("nobud_state", 64'(state), 64'd1);
        chk("nobud_energy", 64'(energy), 64'd1200);
        chk("nobud_alarm", 64'(energy_alarm), 64'd0);

        // Saturation of the energy total
        clear = 1'b1; cyc(0, 0, 0);
        repeat (20) cyc(1, 65535, 0);
        chk("sat_energy", 64'(energy), 64'(EMAX));
        chk("sat_count", 64'(sample_count), 64'd20);
        chk("sat_peak", 64'(peak_power), 64'd65535);
        cyc(1, 65535, 0);
        chk("sat_hold", 64'(energy), 64'(EMAX));

        // enable drop on the tripping sample wins
        clear = 1'b1; cyc(0, 0, 0);
        repeat (3) cyc(1, 5, 1);
        enable = 1'b0; cyc(1, 5, 1);
        chk("en_drop_state", 64'(state), 64'd0);
        chk("en_drop_retry", 64'(retry_count), 64'd0);
        enable = 1'b1; cyc(0, 0, 0);

        // clear coinciding with a sample discards it
        clear = 1'b1; cyc(0, 0, 0);
        cyc(1, 500, 0);
        chk("pre_clr_energy", 64'(energy), 64'd500);
        clear = 1'b1; cyc(1, 700, 0);
        chk("clr_smp_energy", 64'(energy), 64'd0);
        chk("clr_smp_count", 64'(sample_count), 64'd0);

        // Reset mid-trip
        repeat (4) cyc(1, 10, 1);
        chk("mid_trip_state", 64'(state), 64'd2);
        repeat (3) cyc(0, 0, 0);
        reset = 1'b0; cyc(0, 0, 0);
        chk("rtrip_state", 64'(state), 64'd0);
        chk("rtrip_tripped", 64'(tripped), 64'd0);
        chk("rtrip_energy", 64'(energy), 64'd0);
        chk("rtrip_retry", 64'(retry_count), 64'd0);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 499) != 0);
            enable       = ($urandom_range(0, 19) != 0);
            clear        = ($urandom_range(0, 59) == 0);
            sample_valid = ($urandom_range(0, 2) != 0);
            over_load    = ($urandom_range(0, 9) < 6);
            power        = PW'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                energy_limit = ($urandom_range(0, 1) == 0) ? '0 : EW'($urandom_range(50000, 1000000));
            end
            @(negedge clk);
        end
        reset = 1'b1; clear = 1'b0; sample_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
